// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between fetch and data access. Data normally wins; a starvation count forces fetch through.
// Read ack arrives 3 cycles after the request with immediate GNT (2 for stores). One transaction in flight; bus fields are held until BUS_GNT.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    input  logic        IF_FLUSH,
    output logic        IF_ACK,
    output logic [31:0] IF_RDATA,
    input  logic        MEM_RE,
    input  logic        MEM_WE,
    input  logic [31:0] MEM_ADDR,
    input  logic [31:0] MEM_WDATA,
    input  logic [3:0]  MEM_BE,
    output logic        MEM_ACK,
    output logic [31:0] MEM_RDATA,
    output logic        BUS_REQ,
    output logic        BUS_WE,
    output logic [31:0] BUS_ADDR,
    output logic [31:0] BUS_WDATA,
    output logic [3:0]  BUS_BE,
    input  logic        BUS_GNT,
    input  logic        BUS_RVALID,
    input  logic [31:0] BUS_RDATA,
    output logic        STALL_FETCH,
    output logic        STALL_MEM
);
    localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    logic [3:0] starve_cnt;
    logic       owner_if;
    logic       kill;

    logic mem_pend;
    logic if_pend;
    logic if_wins;
    logic mem_wins;
    logic flush_own;
    logic kill_now;

    assign mem_pend  = MEM_RE | MEM_WE;
    assign if_pend   = IF_REQ & ~IF_FLUSH;
    assign if_wins   = if_pend & (~mem_pend | (starve_cnt == STARVE_LIM));
    assign mem_wins  = mem_pend & ~if_wins;
    assign flush_own = owner_if & IF_FLUSH;
    // A flush arriving in the same cycle as the response must still suppress it.
    assign kill_now  = kill | flush_own;

    assign STALL_FETCH = IF_REQ & ~IF_ACK;
    assign STALL_MEM   = mem_pend & ~MEM_ACK;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            owner_if   <= 1'b0;
            kill       <= 1'b0;
            IF_ACK     <= 1'b0;
            MEM_ACK    <= 1'b0;
            IF_RDATA   <= 32'd0;
            MEM_RDATA  <= 32'd0;
            BUS_REQ    <= 1'b0;
            BUS_WE     <= 1'b0;
            BUS_ADDR   <= 32'd0;
            BUS_WDATA  <= 32'd0;
            BUS_BE     <= 4'd0;
        end else begin
            IF_ACK  <= 1'b0;
            MEM_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_wins) begin
                        owner_if   <= 1'b1;
                        kill       <= 1'b0;
                        starve_cnt <= 4'd0;
                        BUS_REQ    <= 1'b1;
                        BUS_WE     <= 1'b0;
                        BUS_ADDR   <= IF_ADDR;
                        BUS_WDATA  <= 32'd0;
                        BUS_BE     <= 4'hF;
                        state      <= ISSUE;
                    end else if (mem_wins) begin
                        owner_if  <= 1'b0;
                        kill      <= 1'b0;
                        if (if_pend && (starve_cnt != STARVE_LIM))
                            starve_cnt <= starve_cnt + 4'd1;
                        BUS_REQ   <= 1'b1;
                        BUS_WE    <= MEM_WE;
                        BUS_ADDR  <= MEM_ADDR;
                        BUS_WDATA <= MEM_WDATA;
                        BUS_BE    <= MEM_WE ? MEM_BE : 4'hF;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (BUS_GNT) begin
                        BUS_REQ <= 1'b0;
                        // Once the slave has accepted, the access must run to completion.
                        if (flush_own)
                            kill <= 1'b1;
                        if (BUS_WE) begin
                            IF_ACK  <= owner_if & ~kill_now;
                            MEM_ACK <= ~owner_if;
                            state   <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (flush_own) begin
                        BUS_REQ <= 1'b0;
                        state   <= IDLE;
                    end
                end
                WAIT: begin
                    if (BUS_RVALID) begin
                        if (owner_if) begin
                            if (!kill_now) begin
                                IF_RDATA <= BUS_RDATA;
                                IF_ACK   <= 1'b1;
                            end
                        end else begin
                            MEM_RDATA <= BUS_RDATA;
                            MEM_ACK   <= 1'b1;
                        end
                        state <= DONE;
                    end else if (flush_own) begin
                        kill <= 1'b1;
                    end
                end
                DONE: begin
                    kill  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle plus directed literal checks.
module tb_mem_port_arbiter;
    localparam int SM = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IF_REQ = 1'b0;
    logic [31:0] IF_ADDR = '0;
    logic        IF_FLUSH = 1'b0;
    logic        IF_ACK;
    logic [31:0] IF_RDATA;
    logic        MEM_RE = 1'b0;
    logic        MEM_WE = 1'b0;
    logic [31:0] MEM_ADDR = '0;
    logic [31:0] MEM_WDATA = '0;
    logic [3:0]  MEM_BE = '0;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic [31:0] BUS_ADDR;
    logic [31:0] BUS_WDATA;
    logic [3:0]  BUS_BE;
    logic        BUS_GNT = 1'b0;
    logic        BUS_RVALID = 1'b0;
    logic [31:0] BUS_RDATA = '0;
    logic        STALL_FETCH;
    logic        STALL_MEM;

    mem_port_arbiter #(.STARVE_MAX(SM)) dut (
        .CLK(CLK), .RST(RST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_FLUSH(IF_FLUSH),
        .IF_ACK(IF_ACK), .IF_RDATA(IF_RDATA),
        .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
        .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
        .BUS_WDATA(BUS_WDATA), .BUS_BE(BUS_BE),
        .BUS_GNT(BUS_GNT), .BUS_RVALID(BUS_RVALID), .BUS_RDATA(BUS_RDATA),
        .STALL_FETCH(STALL_FETCH), .STALL_MEM(STALL_MEM)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;
    bit auto_bus = 1'b0;
    logic [31:0] auto_data = 32'hA0000001;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one in-flight transaction described by flags, not by a state machine copy.
    typedef struct packed {
        bit          busy;
        bit          acc;
        bit          fin;
        bit          kill;
        bit          owner_if;
        bit          we;
        logic [3:0]  starve;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          req;
        bit          if_ack;
        bit          mem_ack;
        logic [31:0] if_rd;
        logic [31:0] mem_rd;
    } mdl_t;

    mdl_t mdl = '0;

    function automatic mdl_t model_next(input mdl_t s);
        mdl_t n;
        bit mem_p;
        bit if_p;
        n = s;
        if (RST) return '0;
        n.if_ack = 1'b0;
        n.mem_ack = 1'b0;
        mem_p = MEM_RE || MEM_WE;
        if_p = IF_REQ && !IF_FLUSH;
        if (s.fin) begin
            n.fin = 1'b0; n.busy = 1'b0; n.kill = 1'b0;
        end else if (!s.busy) begin
            if (if_p && (!mem_p || int'(s.starve) == SM)) begin
                n.busy = 1'b1; n.acc = 1'b0; n.owner_if = 1'b1; n.we = 1'b0; n.kill = 1'b0;
                n.addr = IF_ADDR; n.be = 4'hF; n.req = 1'b1; n.starve = 4'd0;
            end else if (mem_p) begin
                n.busy = 1'b1; n.acc = 1'b0; n.owner_if = 1'b0; n.we = MEM_WE; n.kill = 1'b0;
                n.addr = MEM_ADDR; n.wdata = MEM_WDATA; n.be = MEM_WE ? MEM_BE : 4'hF; n.req = 1'b1;
                if (if_p && int'(s.starve) < SM) n.starve = s.starve + 4'd1;
            end
        end else if (!s.acc) begin
            if (BUS_GNT) begin
                n.acc = 1'b1; n.req = 1'b0;
                if (s.owner_if && IF_FLUSH) n.kill = 1'b1;
                if (s.we) begin n.fin = 1'b1; n.mem_ack = 1'b1; end
            end else if (s.owner_if && IF_FLUSH) begin
                n.busy = 1'b0; n.req = 1'b0;
            end
        end else begin
            if (s.owner_if && IF_FLUSH) n.kill = 1'b1;
            if (BUS_RVALID) begin
                n.fin = 1'b1;
                if (s.owner_if) begin
                    if (!n.kill) begin n.if_ack = 1'b1; n.if_rd = BUS_RDATA; end
                end else begin
                    n.mem_ack = 1'b1; n.mem_rd = BUS_RDATA;
                end
            end
        end
        return n;
    endfunction

    always @(posedge CLK) mdl <= model_next(mdl);

    always @(negedge CLK) begin
        if (cmp_on) begin
            chk("bus_req", 32'(BUS_REQ), 32'(mdl.req));
            chk("if_ack", 32'(IF_ACK), 32'(mdl.if_ack));
            chk("mem_ack", 32'(MEM_ACK), 32'(mdl.mem_ack));
            chk("if_rdata", IF_RDATA, mdl.if_rd);
            chk("mem_rdata", MEM_RDATA, mdl.mem_rd);
            chk("stall_fetch", 32'(STALL_FETCH), 32'(IF_REQ && !mdl.if_ack));
            chk("stall_mem", 32'(STALL_MEM), 32'((MEM_RE || MEM_WE) && !mdl.mem_ack));
            if (mdl.req) begin
                chk("bus_addr", BUS_ADDR, mdl.addr);
                chk("bus_we", 32'(BUS_WE), 32'(mdl.we));
                chk("bus_be", 32'(BUS_BE), 32'(mdl.be));
                if (mdl.we) chk("bus_wdata", BUS_WDATA, mdl.wdata);
            end
        end
    end

    // Advance one cycle; inputs change 1ns after the edge. Optional auto slave grants at once and returns data next cycle.
    task automatic step();
        @(posedge CLK);
        #1;
        if (auto_bus) begin
            BUS_RVALID = 1'b0;
            if (BUS_GNT && !BUS_WE) begin
                BUS_RVALID = 1'b1;
                BUS_RDATA = auto_data;
                auto_data = auto_data + 32'h1111;
            end
            BUS_GNT = BUS_REQ;
        end
    endtask

    task automatic wait_ack(input bit want_if, input int maxc, output int at);
        bit seen;
        at = -1;
        seen = 1'b0;
        for (int c = 0; c < maxc && !seen; c++) begin
            @(negedge CLK);
            if ((want_if && IF_ACK) || (!want_if && MEM_ACK)) begin
                at = c;
                seen = 1'b1;
            end else begin
                step();
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int at;
        int n;
        logic [9:0] pattern;

        // Reset
        step();
        cmp_on = 1'b1;
        step();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_bus_req", 32'(BUS_REQ), 32'd0);
        chk("rst_if_rdata", IF_RDATA, 32'd0);
        chk("rst_mem_rdata", MEM_RDATA, 32'd0);
        chk("rst_acks", 32'({IF_ACK, MEM_ACK}), 32'd0);

        // Lone IF read, exact timing
        step();
        IF_ADDR = 32'h100; IF_REQ = 1'b1;
        @(negedge CLK); chk("t1_stall_c0", 32'(STALL_FETCH), 32'd1);
        step(); BUS_GNT = 1'b1;
        @(negedge CLK); chk("t1_req_c1", 32'(BUS_REQ), 32'd1); chk("t1_addr_c1", BUS_ADDR, 32'h100);
        chk("t1_be_c1", 32'(BUS_BE), 32'hF); chk("t1_stall_c1", 32'(STALL_FETCH), 32'd1);
        step(); BUS_GNT = 1'b0; BUS_RVALID = 1'b1; BUS_RDATA = 32'hDEADBEEF;
        @(negedge CLK); chk("t1_stall_c2", 32'(STALL_FETCH), 32'd1); chk("t1_ack_c2", 32'(IF_ACK), 32'd0);
        step(); BUS_RVALID = 1'b0;
        @(negedge CLK); chk("t1_ack_c3", 32'(IF_ACK), 32'd1); chk("t1_rdata_c3", IF_RDATA, 32'hDEADBEEF);
        chk("t1_stall_c3", 32'(STALL_FETCH), 32'd0);
        step(); IF_REQ = 1'b0;

        // Flush while in ISSUE with GNT low
        step();
        IF_ADDR = 32'h140; IF_REQ = 1'b1;
        step(); IF_REQ = 1'b0; IF_FLUSH = 1'b1;
        @(negedge CLK); chk("t4a_req_issue", 32'(BUS_REQ), 32'd1);
        step(); IF_FLUSH = 1'b0;
        @(negedge CLK); chk("t4a_req_dropped", 32'(BUS_REQ), 32'd0);
        step(); step();
        @(negedge CLK); chk("t4a_no_ack", 32'(IF_ACK), 32'd0);

        // Flush while in WAIT: response consumed, no ack, data kept
        step();
        IF_ADDR = 32'h180; IF_REQ = 1'b1;
        step(); BUS_GNT = 1'b1;
        step(); BUS_GNT = 1'b0; IF_REQ = 1'b0; IF_FLUSH = 1'b1;
        step(); IF_FLUSH = 1'b0; BUS_RVALID = 1'b1; BUS_RDATA = 32'hBADBAD01;
        step(); BUS_RVALID = 1'b0;
        @(negedge CLK); chk("t4b_no_ack", 32'(IF_ACK), 32'd0); chk("t4b_req", 32'(BUS_REQ), 32'd0);
        step();
        @(negedge CLK); chk("t4b_rdata_kept", IF_RDATA, 32'hDEADBEEF);

        // Store with GNT delayed three cycles
        step();
        MEM_ADDR = 32'h300; MEM_WDATA = 32'hCAFEF00D; MEM_BE = 4'hC; MEM_WE = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 4) BUS_GNT = 1'b1;
            @(negedge CLK);
            chk("t5_req_hold", 32'(BUS_REQ), 32'd1);
            chk("t5_addr_hold", BUS_ADDR, 32'h300);
            chk("t5_we_hold", 32'(BUS_WE), 32'd1);
            chk("t5_wdata_hold", BUS_WDATA, 32'hCAFEF00D);
        end
        step(); BUS_GNT = 1'b0;
        @(negedge CLK); chk("t5_mem_ack", 32'(MEM_ACK), 32'd1);
        step(); MEM_WE = 1'b0;
        BUS_RVALID = 1'b1; BUS_RDATA = 32'h55555555;
        step(); step(); BUS_RVALID = 1'b0;
        @(negedge CLK); chk("t5_spur_acks", 32'({IF_ACK, MEM_ACK}), 32'd0);
        chk("t5_spur_if_rdata", IF_RDATA, 32'hDEADBEEF); chk("t5_spur_mem_rdata", MEM_RDATA, 32'd0);

        // IF and store together: store first, then fetch
        auto_bus = 1'b1;
        step();
        IF_ADDR = 32'h1C0; IF_REQ = 1'b1;
        MEM_ADDR = 32'h200; MEM_WDATA = 32'h12345678; MEM_BE = 4'b0011; MEM_WE = 1'b1;
        step();
        @(negedge CLK); chk("t2_we", 32'(BUS_WE), 32'd1); chk("t2_be", 32'(BUS_BE), 32'h3);
        chk("t2_addr", BUS_ADDR, 32'h200); chk("t2_wdata", BUS_WDATA, 32'h12345678);
        step();
        @(negedge CLK); chk("t2_mem_ack_c2", 32'(MEM_ACK), 32'd1); chk("t2_if_ack_c2", 32'(IF_ACK), 32'd0);
        step(); MEM_WE = 1'b0;
        wait_ack(1'b1, 10, at);
        chk("t2_if_ack_cycle", 32'(at), 32'd3);
        chk("t2_if_rdata", IF_RDATA, 32'hA0000001);
        step(); IF_REQ = 1'b0;

        // Starvation: both held, IF must win every fifth round
        step();
        MEM_ADDR = 32'h400; MEM_RE = 1'b1; IF_ADDR = 32'h500; IF_REQ = 1'b1;
        pattern = '0; n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge CLK);
            if (IF_ACK || MEM_ACK) begin
                pattern[n] = IF_ACK;
                n++;
            end
            step();
        end
        MEM_RE = 1'b0; IF_REQ = 1'b0;
        chk("starve_acks", 32'(n), 32'd10);
        chk("starve_order", 32'(pattern), 32'h210);

        // Reset in WAIT, later response ignored
        step();
        auto_bus = 1'b0; BUS_GNT = 1'b0; BUS_RVALID = 1'b0;
        step();
        MEM_ADDR = 32'h600; MEM_RE = 1'b1;
        step(); BUS_GNT = 1'b1;
        step(); BUS_GNT = 1'b0; RST = 1'b1; MEM_RE = 1'b0;
        step(); RST = 1'b0; BUS_RVALID = 1'b1; BUS_RDATA = 32'h77777777;
        @(negedge CLK); chk("rst_wait_req", 32'(BUS_REQ), 32'd0);
        chk("rst_wait_mem_rdata", MEM_RDATA, 32'd0); chk("rst_wait_if_rdata", IF_RDATA, 32'd0);
        step(); BUS_RVALID = 1'b0;
        @(negedge CLK); chk("rst_late_ack", 32'(MEM_ACK), 32'd0); chk("rst_late_rdata", MEM_RDATA, 32'd0);

        // Recovery after reset
        auto_bus = 1'b1; auto_data = 32'h0000BEEF;
        step();
        MEM_ADDR = 32'h640; MEM_RE = 1'b1;
        wait_ack(1'b0, 10, at);
        chk("recover_ack_cycle", 32'(at), 32'd3);
        chk("recover_rdata", MEM_RDATA, 32'h0000BEEF);
        step(); MEM_RE = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
